// File: rtl/alu_issue_ctrl_pkg.sv
// ============================================================================
// Module   : alu_issue_ctrl_pkg
// Brief    : Shared R-type codes, width codes, FSM and latency-class types
//            for the vector ALU issue controller and its neighbours.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_issue_ctrl_pkg;

    // R-type function codes understood by the vector ALU
    localparam logic [0:5] VAND   = 6'b000001;
    localparam logic [0:5] VOR    = 6'b000010;
    localparam logic [0:5] VXOR   = 6'b000011;
    localparam logic [0:5] VNOT   = 6'b000100;
    localparam logic [0:5] VMOV   = 6'b000101;
    localparam logic [0:5] VADD   = 6'b000110;
    localparam logic [0:5] VSUB   = 6'b000111;
    localparam logic [0:5] VMULEU = 6'b001000;
    localparam logic [0:5] VMULOU = 6'b001001;
    localparam logic [0:5] VSLL   = 6'b001010;
    localparam logic [0:5] VSRL   = 6'b001011;
    localparam logic [0:5] VSRA   = 6'b001100;
    localparam logic [0:5] VRTTH  = 6'b001101;
    localparam logic [0:5] VDIV   = 6'b001110;
    localparam logic [0:5] VMOD   = 6'b001111;
    localparam logic [0:5] VSQEU  = 6'b010000;
    localparam logic [0:5] VSQOU  = 6'b010001;
    localparam logic [0:5] VSQRT  = 6'b010010;

    // Element width codes
    localparam logic [0:1] WW_8  = 2'b00;
    localparam logic [0:1] WW_16 = 2'b01;
    localparam logic [0:1] WW_32 = 2'b10;
    localparam logic [0:1] WW_64 = 2'b11;

    // Opcode the ALU expects for every R-type operation
    localparam logic [0:5] OPCODE_RTYPE = 6'b000001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        LAT_SEL_SIMPLE = 2'd0,
        LAT_SEL_MUL    = 2'd1,
        LAT_SEL_LONG   = 2'd2
    } lat_sel_e;

    // Largest of the three class latencies; sizes the hold counter
    function automatic int lat_max(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_issue_ctrl_if.sv
// ============================================================================
// Module   : alu_issue_ctrl_if
// Brief    : Issue-side request and result handshakes of the ALU issue
//            controller. master = issue stage / consumer, slave = controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_issue_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [0:63] in_rA;
    logic [0:63] in_rB;
    logic [0:5]  in_rins;
    logic [0:1]  in_ww;
    logic        out_valid;
    logic        out_ready;
    logic [0:63] out_data;
    logic        out_err;

    modport master (
        output in_valid, in_rA, in_rB, in_rins, in_ww, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_rA, in_rB, in_rins, in_ww, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

`default_nettype wire

// File: rtl/alu_issue_ctrl_op_class.sv
// ============================================================================
// Module   : alu_issue_ctrl_op_class
// Brief    : Combinational op classifier: function code + width -> legality
//            and latency class.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_ctrl_op_class
    import alu_issue_ctrl_pkg::*;
(
    input  wire logic [0:5] rins_i,
    input  wire logic [0:1] ww_i,
    output lat_sel_e        lat_sel_o,
    output logic            legal_o
);

    // Widening multiplies/squares have no 128-bit result, so 64-bit lanes are rejected
    always_comb begin
        legal_o   = 1'b1;
        lat_sel_o = LAT_SEL_SIMPLE;
        case (rins_i)
            VAND, VOR, VXOR, VNOT, VMOV, VADD, VSUB,
            VSLL, VSRL, VSRA, VRTTH: begin
                lat_sel_o = LAT_SEL_SIMPLE;
            end
            VMULEU, VMULOU, VSQEU, VSQOU: begin
                lat_sel_o = LAT_SEL_MUL;
                legal_o   = (ww_i != WW_64);
            end
            VDIV, VMOD, VSQRT: begin
                lat_sel_o = LAT_SEL_LONG;
            end
            default: begin
                legal_o = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
// ============================================================================
// Module   : alu_issue_ctrl
// Brief    : Sequencer in front of the vector ALU. Registers one R-type op,
//            holds it for a class-dependent settle time, then presents the
//            captured ALU result on a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int LAT_SIMPLE = 1,
    parameter int LAT_MUL    = 2,
    parameter int LAT_LONG   = 4
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    alu_issue_ctrl_if.slave  io,
    output logic [0:63]      alu_rA,
    output logic [0:63]      alu_rB,
    output logic [0:5]       alu_rins,
    output logic [0:5]       alu_opcode,
    output logic [0:1]       alu_ww,
    input  wire logic [0:63] alu_out,
    output logic             busy
);

    localparam int CNT_W = $clog2(lat_max(LAT_SIMPLE, LAT_MUL, LAT_LONG)) + 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [0:63]        rA_q, rA_d;
    logic [0:63]        rB_q, rB_d;
    logic [0:5]         rins_q, rins_d;
    logic [0:1]         ww_q, ww_d;
    logic [0:63]        out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               out_err_q, out_err_d;

    logic               in_ready_w;
    logic               accept_w;
    logic               legal_w;
    lat_sel_e           lat_sel_w;
    logic [CNT_W-1:0]   cnt_load_w;

    // Classify the incoming op straight off the request bus
    alu_issue_ctrl_op_class u_op_class (
        .rins_i    (io.in_rins),
        .ww_i      (io.in_ww),
        .lat_sel_o (lat_sel_w),
        .legal_o   (legal_w)
    );

    // Hold count is latency-1: the accept edge itself is the first settle cycle
    always_comb begin
        cnt_load_w = CNT_W'(LAT_SIMPLE - 1);
        case (lat_sel_w)
            LAT_SEL_MUL:  cnt_load_w = CNT_W'(LAT_MUL - 1);
            LAT_SEL_LONG: cnt_load_w = CNT_W'(LAT_LONG - 1);
            default:      cnt_load_w = CNT_W'(LAT_SIMPLE - 1);
        endcase
    end

    // A result being popped frees the controller in the same cycle
    assign in_ready_w = (state_q == ST_IDLE) ||
                        ((state_q == ST_DONE) && io.out_ready);
    assign accept_w   = io.in_valid && in_ready_w;

    // Next-state, counter and datapath register updates
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rA_d        = rA_q;
        rB_d        = rB_q;
        rins_d      = rins_q;
        ww_d        = ww_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_err_d   = out_err_q;

        case (state_q)
            ST_EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    out_data_d  = alu_out;
                    out_err_d   = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (io.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
            end
        endcase

        // Accept overrides the DONE pop so back-to-back ops need no idle cycle
        if (accept_w) begin
            rA_d   = io.in_rA;
            rB_d   = io.in_rB;
            rins_d = io.in_rins;
            ww_d   = io.in_ww;
            if (legal_w) begin
                cnt_d       = cnt_load_w;
                out_valid_d = 1'b0;
                state_d     = ST_EXEC;
            end else begin
                out_data_d  = '0;
                out_err_d   = 1'b1;
                out_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
        end
    end

    // State and datapath registers; reset aborts any op in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rA_q        <= '0;
            rB_q        <= '0;
            rins_q      <= '0;
            ww_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rA_q        <= rA_d;
            rB_q        <= rB_d;
            rins_q      <= rins_d;
            ww_q        <= ww_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_err_q   <= out_err_d;
        end
    end

    assign io.in_ready  = in_ready_w;
    assign io.out_valid = out_valid_q;
    assign io.out_data  = out_data_q;
    assign io.out_err   = out_err_q;
    assign alu_rA       = rA_q;
    assign alu_rB       = rB_q;
    assign alu_rins     = rins_q;
    assign alu_ww       = ww_q;
    assign alu_opcode   = OPCODE_RTYPE;
    assign busy         = (state_q != ST_IDLE);

endmodule

`default_nettype wire
